// File: rtl/sha1_host_driver.sv
// sha1_host_driver
// Bus initiator that feeds pre-padded 512-bit message blocks into the SHA-1
// register-mapped slave. It issues init or next, polls STATUS, and after
// the last block of a message it reads back the 160-bit digest.
//
// Optional feature macro: SHA1_DRV_TIMEOUT_EN
//   When defined, POLL aborts with bus_err after POLL_TIMEOUT cycles without
//   completion. When undefined, POLL waits indefinitely.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   blk_valid/ready     block handshake; blk_data[511:480] is word 0
//   blk_first/last      block opens (init) / closes (read digest) a message
//   dig_valid/ready     digest handshake; dig_data[159:128] is H0
//   busy                driver not idle
//   bus_err             sticky slave-error / timeout flag
//   cs/we/address/write_data/read_data/error   slave bus
module sha1_host_driver #(
   parameter int POLL_SETTLE  = 4,
   parameter int POLL_TIMEOUT = 1024
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         blk_valid,
   output logic         blk_ready,
   input  logic [511:0] blk_data,
   input  logic         blk_first,
   input  logic         blk_last,
   output logic         dig_valid,
   input  logic         dig_ready,
   output logic [159:0] dig_data,
   output logic         busy,
   output logic         bus_err,
   output logic         cs,
   output logic         we,
   output logic [7:0]   address,
   output logic [31:0]  write_data,
   input  logic [31:0]  read_data,
   input  logic         error
);

   // One shared counter walks block words, settle cycles and digest words.
   localparam int CNT_W = (POLL_SETTLE > 16) ? $clog2(POLL_SETTLE) : 4;

   typedef enum logic [2:0] {
      S_IDLE, S_WR_BLK, S_WR_CTRL, S_SETTLE, S_POLL, S_RD_DIG, S_OUT
   } state_t;

   state_t         state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [511:0]   blk_reg, blk_next;
   logic           first_reg, first_next;
   logic           last_reg, last_next;
   logic [159:0]   dig_reg, dig_next;
   logic           bus_err_reg, bus_err_next;
   logic           poll_done;
   logic [31:0]    blk_word [16];

`ifdef SHA1_DRV_TIMEOUT_EN
   localparam int PT_W = $clog2(POLL_TIMEOUT + 1);
   logic [PT_W-1:0] poll_cnt_reg, poll_cnt_next;
`else
   wire unused_poll_timeout = |POLL_TIMEOUT;
`endif

   // Word n of the captured block sits at the top end, MSB first.
   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_word
         assign blk_word[gi] = blk_reg[511-32*gi -: 32];
      end
   endgenerate

   // The final block also needs the digest-valid bit before reading H0..H4.
   assign poll_done = read_data[0] && (!last_reg || read_data[1]);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg   <= S_IDLE;
         cnt_reg     <= '0;
         blk_reg     <= '0;
         first_reg   <= 1'b0;
         last_reg    <= 1'b0;
         dig_reg     <= '0;
         bus_err_reg <= 1'b0;
`ifdef SHA1_DRV_TIMEOUT_EN
         poll_cnt_reg <= '0;
`endif
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         blk_reg     <= blk_next;
         first_reg   <= first_next;
         last_reg    <= last_next;
         dig_reg     <= dig_next;
         bus_err_reg <= bus_err_next;
`ifdef SHA1_DRV_TIMEOUT_EN
         poll_cnt_reg <= poll_cnt_next;
`endif
      end
   end

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      blk_next     = blk_reg;
      first_next   = first_reg;
      last_next    = last_reg;
      dig_next     = dig_reg;
      bus_err_next = bus_err_reg;
`ifdef SHA1_DRV_TIMEOUT_EN
      poll_cnt_next = poll_cnt_reg;
`endif
      cs         = 1'b0;
      we         = 1'b0;
      address    = 8'h00;
      write_data = 32'h0;

      case (state_reg)
         S_IDLE: begin
            if (blk_valid) begin
               blk_next   = blk_data;
               first_next = blk_first;
               last_next  = blk_last;
               cnt_next   = '0;
               state_next = S_WR_BLK;
            end
         end
         S_WR_BLK: begin
            cs         = 1'b1;
            we         = 1'b1;
            address    = {4'h1, cnt_reg[3:0]};
            write_data = blk_word[cnt_reg[3:0]];
            if (cnt_reg[3:0] == 4'd15) begin
               cnt_next   = '0;
               state_next = S_WR_CTRL;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         S_WR_CTRL: begin
            cs         = 1'b1;
            we         = 1'b1;
            address    = 8'h08;
            write_data = first_reg ? 32'h1 : 32'h2;
            cnt_next   = '0;
            state_next = S_SETTLE;
         end
         S_SETTLE: begin
            // Lets the slave's registered ctrl/status path drop stale ready.
            if (cnt_reg == CNT_W'(POLL_SETTLE - 1)) begin
               cnt_next   = '0;
               state_next = S_POLL;
`ifdef SHA1_DRV_TIMEOUT_EN
               poll_cnt_next = '0;
`endif
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         S_POLL: begin
            cs      = 1'b1;
            address = 8'h09;
            if (poll_done) begin
               cnt_next   = '0;
               state_next = last_reg ? S_RD_DIG : S_IDLE;
            end
`ifdef SHA1_DRV_TIMEOUT_EN
            else if (poll_cnt_reg == PT_W'(POLL_TIMEOUT - 1)) begin
               bus_err_next = 1'b1;
               state_next   = S_IDLE;
            end else begin
               poll_cnt_next = poll_cnt_reg + PT_W'(1);
            end
`endif
         end
         S_RD_DIG: begin
            cs      = 1'b1;
            address = {5'b00100, cnt_reg[2:0]};
            for (int k = 0; k < 5; k++) begin
               if (cnt_reg[2:0] == 3'(k)) dig_next[(4-k)*32 +: 32] = read_data;
            end
            if (cnt_reg[2:0] == 3'd4) begin
               cnt_next   = '0;
               state_next = S_OUT;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         S_OUT: begin
            if (dig_ready) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase

      // A decode error on any bus cycle abandons the whole operation.
      if (cs && error) begin
         bus_err_next = 1'b1;
         state_next   = S_IDLE;
      end
   end

   assign blk_ready = (state_reg == S_IDLE);
   assign busy      = (state_reg != S_IDLE);
   assign dig_valid = (state_reg == S_OUT);
   assign dig_data  = dig_reg;
   assign bus_err   = bus_err_reg;

endmodule

// File: tb/tb_sha1_host_driver.sv
// Testbench for sha1_host_driver: behavioural SHA-1 slave, bus monitor with
// write/read scoreboards, digest scoreboard, one task per scenario.
module tb_sha1_host_driver;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         blk_valid = 1'b0;
   logic         blk_ready;
   logic [511:0] blk_data = '0;
   logic         blk_first = 1'b0;
   logic         blk_last = 1'b0;
   logic         dig_valid;
   logic         dig_ready = 1'b0;
   logic [159:0] dig_data;
   logic         busy;
   logic         bus_err;
   logic         cs;
   logic         we;
   logic [7:0]   address;
   logic [31:0]  write_data;
   logic [31:0]  read_data;
   logic         error;

   always #5 clk = ~clk;

   sha1_host_driver #(.POLL_SETTLE(4), .POLL_TIMEOUT(16)) dut (
      .clk(clk), .reset_n(reset_n),
      .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
      .blk_first(blk_first), .blk_last(blk_last),
      .dig_valid(dig_valid), .dig_ready(dig_ready), .dig_data(dig_data),
      .busy(busy), .bus_err(bus_err),
      .cs(cs), .we(we), .address(address), .write_data(write_data),
      .read_data(read_data), .error(error)
   );

   int n_cmp = 0;
   int n_err = 0;

   localparam logic [159:0] IV      = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;
   localparam logic [159:0] DIG_ABC = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
   localparam logic [159:0] DIG_TWO = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;
   localparam logic [511:0] BLK_ABC = {32'h61626380, {14{32'h0}}, 32'h00000018};
   localparam logic [511:0] BLK_T1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                       32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                       32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                       32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [511:0] BLK_T2  = {{15{32'h0}}, 32'h000001c0};
   localparam int SLAVE_LAT = 10;

   // ---------------- behavioural SHA-1 slave ----------------
   function automatic logic [159:0] sha1_compress(input logic [159:0] h, input logic [511:0] m);
      logic [31:0] w [80];
      logic [31:0] a, b, c, d, e, f, k, t, x;
      for (int i = 0; i < 16; i++) w[i] = m[511-32*i -: 32];
      for (int i = 16; i < 80; i++) begin
         x = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
         w[i] = {x[30:0], x[31]};
      end
      a = h[159:128]; b = h[127:96]; c = h[95:64]; d = h[63:32]; e = h[31:0];
      for (int i = 0; i < 80; i++) begin
         if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5a827999; end
         else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ed9eba1; end
         else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8f1bbcdc; end
         else             begin f = b ^ c ^ d;                   k = 32'hca62c1d6; end
         t = {a[26:0], a[31:27]} + f + e + k + w[i];
         e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
      end
      return {h[159:128] + a, h[127:96] + b, h[95:64] + c, h[63:32] + d, h[31:0] + e};
   endfunction

   logic [31:0]  smem [16];
   logic [511:0] sblk;
   logic [159:0] sh = '0;
   int           sbusy = 0;
   logic         svalid = 1'b0;
   logic         stuck_status = 1'b0;
   logic         force_err = 1'b0;

   always_comb begin
      sblk = '0;
      for (int i = 0; i < 16; i++) sblk[511-32*i -: 32] = smem[i];
   end

   always @(posedge clk) begin
      if (sbusy > 0) begin
         sbusy <= sbusy - 1;
         if (sbusy == 1) svalid <= 1'b1;
      end
      if (cs && we) begin
         if (address[7:4] == 4'h1) smem[address[3:0]] <= write_data;
         else if (address == 8'h08) begin
            if (write_data[0]) sh <= sha1_compress(IV, sblk);
            else if (write_data[1]) sh <= sha1_compress(sh, sblk);
            sbusy  <= SLAVE_LAT;
            svalid <= 1'b0;
         end
      end
   end

   always_comb begin
      read_data = '0;
      if (cs && !we) begin
         if (address == 8'h09)
            read_data = stuck_status ? 32'h0 : {30'h0, svalid, (sbusy == 0)};
         else if (address >= 8'h20 && address <= 8'h24)
            read_data = sh[159-32*(int'(address)-32) -: 32];
      end
   end

   assign error = force_err && cs && we && (address == 8'h12);

   // ---------------- scoreboards and bus monitor ----------------
   logic [39:0]  exp_wr_q [$];
   logic [7:0]   exp_rd_q [$];
   logic [159:0] exp_dig_q [$];
   int           poll_count = 0;
   logic [39:0]  mon_wr;
   logic [7:0]   mon_rd;

   always @(negedge clk) begin
      if (reset_n && cs) begin
         if (we) begin
            n_cmp++;
            if (exp_wr_q.size() == 0) begin
               n_err++;
               $display("FAIL bus_write unexpected: got addr=%h data=%h, expected none", address, write_data);
            end else begin
               mon_wr = exp_wr_q.pop_front();
               if ({address, write_data} !== mon_wr) begin
                  n_err++;
                  $display("FAIL bus_write: got addr=%h data=%h, expected addr=%h data=%h",
                           address, write_data, mon_wr[39:32], mon_wr[31:0]);
               end
            end
         end else if (address == 8'h09) begin
            poll_count++;
         end else begin
            n_cmp++;
            if (exp_rd_q.size() == 0) begin
               n_err++;
               $display("FAIL bus_read unexpected: got addr=%h, expected none", address);
            end else begin
               mon_rd = exp_rd_q.pop_front();
               if (address !== mon_rd) begin
                  n_err++;
                  $display("FAIL bus_read: got addr=%h, expected addr=%h", address, mon_rd);
               end
            end
         end
      end
   end

   // ---------------- helpers (all end at a sample point: #1 after posedge) ----------------
   task automatic send_block(input logic [511:0] b, input logic f, input logic l,
                             input int n_wr, input bit push_rd);
      int t;
      for (int i = 0; i < 16 && i < n_wr; i++) exp_wr_q.push_back({8'(16 + i), b[511-32*i -: 32]});
      if (n_wr > 16) exp_wr_q.push_back({8'h08, f ? 32'h1 : 32'h2});
      if (push_rd && l) for (int k = 0; k < 5; k++) exp_rd_q.push_back(8'(32 + k));
      t = 0;
      while (blk_ready !== 1'b1 && t < 300) begin
         @(posedge clk); #1; t++;
      end
      n_cmp++;
      if (blk_ready !== 1'b1) begin
         n_err++;
         $display("FAIL blk_ready_wait: got %b, expected 1 within 300 cycles", blk_ready);
      end
      blk_data = b; blk_first = f; blk_last = l; blk_valid = 1'b1;
      @(posedge clk); #1;
      blk_valid = 1'b0;
      $display("block sent first=%0b last=%0b word0=%h", f, l, b[511:480]);
   endtask

   task automatic wait_idle(input string name);
      int t = 0;
      while (busy !== 1'b0 && t < 300) begin
         @(posedge clk); #1; t++;
      end
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL %s idle_wait: busy got %b, expected 0", name, busy);
      end
   endtask

   task automatic wait_dig_valid(input string name);
      int t = 0;
      while (dig_valid !== 1'b1 && t < 400) begin
         @(posedge clk); #1; t++;
      end
      n_cmp++;
      if (dig_valid !== 1'b1) begin
         n_err++;
         $display("FAIL %s dig_valid_wait: got %b, expected 1", name, dig_valid);
      end
   endtask

   task automatic take_digest(input string name);
      logic [159:0] exp_d;
      wait_dig_valid(name);
      exp_d = exp_dig_q.pop_front();
      n_cmp++;
      if (dig_data !== exp_d) begin
         n_err++;
         $display("FAIL %s dig_data: got %h, expected %h", name, dig_data, exp_d);
      end
      $display("digest %s received %h", name, dig_data);
      dig_ready = 1'b1;
      @(posedge clk); #1;
      dig_ready = 1'b0;
      n_cmp++;
      if (dig_valid !== 1'b0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL %s after_take: dig_valid=%b busy=%b, expected 0 0", name, dig_valid, busy);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      #1;
      n_cmp++;
      if ({cs, we, address, write_data, dig_valid, dig_data, bus_err, busy} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: cs=%b we=%b addr=%h wd=%h dv=%b dd=%h be=%b busy=%b, expected all 0",
                  cs, we, address, write_data, dig_valid, dig_data, bus_err, busy);
      end
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (blk_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_blk_ready: got %b, expected 1", blk_ready);
      end
      // dig_ready without a digest has no effect
      dig_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      dig_ready = 1'b0;
      n_cmp++;
      if (busy !== 1'b0 || dig_valid !== 1'b0) begin
         n_err++;
         $display("FAIL stray_dig_ready: busy=%b dig_valid=%b, expected 0 0", busy, dig_valid);
      end
   endtask

   task automatic test_abc();
      poll_count = 0;
      exp_dig_q.push_back(DIG_ABC);
      send_block(BLK_ABC, 1'b1, 1'b1, 17, 1'b1);
      take_digest("abc");
      n_cmp++;
      if (poll_count == 0 || exp_wr_q.size() != 0 || exp_rd_q.size() != 0) begin
         n_err++;
         $display("FAIL abc_trace: polls=%0d wr_left=%0d rd_left=%0d, expected polls>0 and 0 0",
                  poll_count, exp_wr_q.size(), exp_rd_q.size());
      end
   endtask

   task automatic test_two_block();
      exp_dig_q.push_back(DIG_TWO);
      send_block(BLK_T1, 1'b1, 1'b0, 17, 1'b1);
      wait_idle("two_block_first");
      n_cmp++;
      if (dig_valid !== 1'b0) begin
         n_err++;
         $display("FAIL two_block_mid_dig_valid: got %b, expected 0", dig_valid);
      end
      send_block(BLK_T2, 1'b0, 1'b1, 17, 1'b1);
      take_digest("two_block");
   endtask

   task automatic test_back_to_back_hold();
      logic [159:0] exp_d;
      int bad = 0;
      exp_dig_q.push_back(DIG_ABC);
      send_block(BLK_ABC, 1'b1, 1'b1, 17, 1'b1);
      wait_dig_valid("hold");
      exp_d = exp_dig_q.pop_front();
      blk_data = BLK_T1; blk_first = 1'b1; blk_last = 1'b0; blk_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         n_cmp++;
         if (dig_valid !== 1'b1 || dig_data !== exp_d || blk_ready !== 1'b0 || cs !== 1'b0) begin
            n_err++;
            bad++;
            if (bad < 4)
               $display("FAIL hold_cycle%0d: dv=%b dd=%h br=%b cs=%b, expected 1 %h 0 0",
                        i, dig_valid, dig_data, blk_ready, cs, exp_d);
         end
         @(posedge clk); #1;
      end
      blk_valid = 1'b0;
      dig_ready = 1'b1;
      @(posedge clk); #1;
      dig_ready = 1'b0;
      n_cmp++;
      if (busy !== 1'b0 || dig_valid !== 1'b0 || blk_ready !== 1'b1) begin
         n_err++;
         $display("FAIL hold_release: busy=%b dv=%b br=%b, expected 0 0 1", busy, dig_valid, blk_ready);
      end
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL hold_no_accept: busy got %b, expected 0", busy);
      end
   endtask

   task automatic test_error();
      int t = 0;
      force_err = 1'b1;
      send_block(BLK_ABC, 1'b1, 1'b1, 3, 1'b0);
      while (!(cs === 1'b1 && we === 1'b1 && address === 8'h12) && t < 40) begin
         @(posedge clk); #1; t++;
      end
      @(posedge clk); #1;
      force_err = 1'b0;
      n_cmp++;
      if (bus_err !== 1'b1 || busy !== 1'b0 || dig_valid !== 1'b0) begin
         n_err++;
         $display("FAIL error_abort: bus_err=%b busy=%b dv=%b, expected 1 0 0", bus_err, busy, dig_valid);
      end
      repeat (30) @(posedge clk);
      #1;
      n_cmp++;
      if (busy !== 1'b0 || dig_valid !== 1'b0 || bus_err !== 1'b1 || exp_wr_q.size() != 0) begin
         n_err++;
         $display("FAIL error_after: busy=%b dv=%b bus_err=%b wr_left=%0d, expected 0 0 1 0",
                  busy, dig_valid, bus_err, exp_wr_q.size());
      end
   endtask

   task automatic test_reset_mid();
      int t = 0;
      send_block(BLK_ABC, 1'b1, 1'b1, 17, 1'b0);
      while (!(cs === 1'b1 && we === 1'b0 && address === 8'h09) && t < 60) begin
         @(posedge clk); #1; t++;
      end
      n_cmp++;
      if (address !== 8'h09) begin
         n_err++;
         $display("FAIL reset_mid_reach_poll: addr got %h, expected 09", address);
      end
      reset_n = 1'b0;
      #1;
      n_cmp++;
      if (cs !== 1'b0 || dig_valid !== 1'b0 || bus_err !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mid_async: cs=%b dv=%b be=%b, expected 0 0 0", cs, dig_valid, bus_err);
      end
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (blk_ready !== 1'b1 || busy !== 1'b0 || bus_err !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mid_release: br=%b busy=%b be=%b, expected 1 0 0", blk_ready, busy, bus_err);
      end
      exp_dig_q.push_back(DIG_ABC);
      send_block(BLK_ABC, 1'b1, 1'b1, 17, 1'b1);
      take_digest("abc_resend");
   endtask

`ifdef SHA1_DRV_TIMEOUT_EN
   task automatic test_timeout();
      int t = 0;
      stuck_status = 1'b1;
      poll_count = 0;
      send_block(BLK_ABC, 1'b1, 1'b1, 17, 1'b0);
      while (bus_err !== 1'b1 && t < 300) begin
         @(posedge clk); #1; t++;
      end
      stuck_status = 1'b0;
      n_cmp++;
      if (bus_err !== 1'b1 || poll_count != 16 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL timeout: bus_err=%b polls=%0d busy=%b, expected 1 16 0", bus_err, poll_count, busy);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_abc();
      test_two_block();
      test_back_to_back_hold();
      test_error();
      test_reset_mid();
`ifdef SHA1_DRV_TIMEOUT_EN
      test_timeout();
`endif
      repeat (5) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
